// File: rtl/cnn_result_uart.sv
// cnn_result_uart
//
// Purpose: sits after the CNN core on the FPGA top level. It measures how many
// clock cycles pass from the `start` pulse to the `done` pulse and latches the
// class result for the LEDs. It then sends a 7-byte report frame over a UART,
// LSB first, with this layout:
//     FRAME_HDR, result, cycles[31:24], cycles[23:16], cycles[15:8],
//     cycles[7:0], chk
// where chk is the XOR of bytes 1..5.
//
// Ports:
//     clk         system clock
//     rst         synchronous, active-high reset
//     start       single-cycle pulse that launches the CNN core
//     done        single-cycle completion pulse from the CNN core
//     result[7:0] class result, valid while done=1
//     led_result  result latched on the last done
//     uart_tx     serial line, idles high
//     busy        high while a frame is being transmitted
//     overrun     sticky flag; a done arrived while a frame was in flight
//
// Parameters:
//     CLKS_PER_BIT  clock cycles per UART bit (legal range 4..65535)
//     FRAME_HDR     first byte of every frame
//
// Optional build macro CNN_UART_PARITY_EN: adds an even-parity bit between
// data bit 7 and the stop bit, so each byte takes 11 bit-times instead of 10.

module cnn_result_uart #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  FRAME_HDR    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    input  logic [7:0] result,
    output logic [7:0] led_result,
    output logic       uart_tx,
    output logic       busy,
    output logic       overrun
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic {
        M_IDLE,
        M_RUN
    } m_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
`ifdef CNN_UART_PARITY_EN
        T_PARITY,
`endif
        T_STOP
    } t_state_t;

    // ------------------------------------------------------------------
    // Latency measurement
    // ------------------------------------------------------------------
    m_state_t    m_state_reg, m_state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] cycles_now;

    // The start cycle itself counts as the first cycle. The counter is
    // therefore loaded with 1, and a done N cycles after start sees N.
    always_comb begin
        m_state_next = m_state_reg;
        cnt_next     = cnt_reg;
        if (start) begin
            m_state_next = M_RUN;
            cnt_next     = 32'd1;
        end else if (done) begin
            m_state_next = M_IDLE;
        end else if (m_state_reg == M_RUN && cnt_reg != 32'hFFFF_FFFF) begin
            cnt_next = cnt_reg + 32'd1;
        end
    end

    // A done while no run is in progress reports zero cycles. The counter
    // may still hold a stale value from the previous run.
    assign cycles_now = (m_state_reg == M_RUN) ? cnt_reg : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_state_reg <= M_IDLE;
            cnt_reg     <= 32'd0;
        end else begin
            m_state_reg <= m_state_next;
            cnt_reg     <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Result latch, frame capture, overrun
    // ------------------------------------------------------------------
    t_state_t    t_state_reg, t_state_next;
    logic [15:0] baud_cnt_reg, baud_cnt_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [2:0]  byte_idx_reg, byte_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        tx_reg, tx_next;
    logic        busy_reg, busy_next;
    logic        overrun_reg;
    logic [7:0]  led_reg;
    logic        baud_done;
    logic        frame_end;
    logic        accept;
    logic [2:0]  next_byte;
`ifdef CNN_UART_PARITY_EN
    logic        par_reg, par_next;
`endif

    // Bytes 1..6 of the frame being captured. Byte 0 is the constant header.
    logic [7:0] cap_bytes [1:6];
    logic [7:0] frame_reg [1:6];

    assign baud_done = (baud_cnt_reg == BAUD_LAST);
    assign frame_end = (t_state_reg == T_STOP) && baud_done && (byte_idx_reg == 3'd6);
    // The final cycle of the last stop bit counts as free. A done arriving
    // in that cycle starts the next frame back-to-back, not as an overrun.
    assign accept    = done && (!busy_reg || frame_end);
    assign next_byte = byte_idx_reg + 3'd1;

    assign cap_bytes[1] = result;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cycles_bytes
            assign cap_bytes[gi + 2] = cycles_now[31 - 8*gi -: 8];
        end
    endgenerate

    assign cap_bytes[6] = cap_bytes[1] ^ cap_bytes[2] ^ cap_bytes[3]
                        ^ cap_bytes[4] ^ cap_bytes[5];

    generate
        for (gi = 1; gi <= 6; gi++) begin : g_frame_store
            always_ff @(posedge clk) begin
                if (rst) begin
                    frame_reg[gi] <= 8'h00;
                end else if (accept) begin
                    frame_reg[gi] <= cap_bytes[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg     <= 8'h00;
            overrun_reg <= 1'b0;
        end else begin
            if (done) begin
                led_reg <= result;
            end
            if (done && !accept) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    // uart_tx is registered. The value for the next bit is chosen in the
    // same cycle the state changes, so the line and the state stay aligned.
    // The start bit therefore appears on the line right after the
    // capturing edge.
    always_comb begin
        t_state_next  = t_state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_idx_next = byte_idx_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
`ifdef CNN_UART_PARITY_EN
        par_next      = par_reg;
`endif
        case (t_state_reg)
            T_IDLE: begin
                if (accept) begin
                    t_state_next  = T_START;
                    baud_cnt_next = 16'd0;
                    byte_idx_next = 3'd0;
                    shift_next    = FRAME_HDR;
`ifdef CNN_UART_PARITY_EN
                    par_next      = ^FRAME_HDR;
`endif
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            T_START: begin
                if (baud_done) begin
                    baud_cnt_next = 16'd0;
                    bit_cnt_next  = 4'd0;
                    t_state_next  = T_DATA;
                    tx_next       = shift_reg[0];
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            T_DATA: begin
                if (baud_done) begin
                    baud_cnt_next = 16'd0;
                    if (bit_cnt_reg == 4'd7) begin
`ifdef CNN_UART_PARITY_EN
                        t_state_next = T_PARITY;
                        tx_next      = par_reg;
`else
                        t_state_next = T_STOP;
                        tx_next      = 1'b1;
`endif
                    end else begin
                        // shift_reg[0] is the bit on the line now.
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
`ifdef CNN_UART_PARITY_EN
            T_PARITY: begin
                if (baud_done) begin
                    baud_cnt_next = 16'd0;
                    t_state_next  = T_STOP;
                    tx_next       = 1'b1;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
`endif
            T_STOP: begin
                if (baud_done) begin
                    baud_cnt_next = 16'd0;
                    if (byte_idx_reg == 3'd6) begin
                        if (accept) begin
                            // Start the next frame with no idle gap.
                            t_state_next  = T_START;
                            byte_idx_next = 3'd0;
                            shift_next    = FRAME_HDR;
`ifdef CNN_UART_PARITY_EN
                            par_next      = ^FRAME_HDR;
`endif
                            tx_next       = 1'b0;
                        end else begin
                            t_state_next = T_IDLE;
                            busy_next    = 1'b0;
                            tx_next      = 1'b1;
                        end
                    end else begin
                        t_state_next  = T_START;
                        byte_idx_next = next_byte;
                        shift_next    = frame_reg[next_byte];
`ifdef CNN_UART_PARITY_EN
                        par_next      = ^frame_reg[next_byte];
`endif
                        tx_next       = 1'b0;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            default: begin
                t_state_next = T_IDLE;
                busy_next    = 1'b0;
                tx_next      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state_reg  <= T_IDLE;
            baud_cnt_reg <= 16'd0;
            bit_cnt_reg  <= 4'd0;
            byte_idx_reg <= 3'd0;
            shift_reg    <= 8'h00;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
`ifdef CNN_UART_PARITY_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            t_state_reg  <= t_state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_idx_reg <= byte_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
`ifdef CNN_UART_PARITY_EN
            par_reg      <= par_next;
`endif
        end
    end

    assign led_result = led_reg;
    assign uart_tx    = tx_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_cnn_result_uart.sv
// Testbench for cnn_result_uart at CLKS_PER_BIT=10. Inputs are driven and
// outputs are sampled on the falling clock edge.
//
// The bench decodes each frame cycle by cycle. Every bit must hold its value
// for exactly CLKS_PER_BIT cycles, and busy must stay high for the whole
// frame.

module tb_cnn_result_uart;

    localparam int CPB = 10;
`ifdef CNN_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = 7 * NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic [7:0] result;
    logic [7:0] led_result;
    logic       uart_tx;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    cnn_result_uart #(
        .CLKS_PER_BIT(CPB),
        .FRAME_HDR   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .result    (result),
        .led_result(led_result),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          gap;     // cycles from start to done; -1 means no start
        logic [7:0]  res;
        logic [55:0] frame;   // expected bytes 0..6, byte 0 in the MSBs
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Pulses done for one cycle. On return we are at the first falling edge
    // after the capturing edge.
    task automatic send_done(input logic [7:0] res);
        done   = 1'b1;
        result = res;
        @(negedge clk);
        done = 1'b0;
    endtask

    // Decodes one frame, starting at the first falling edge after capture.
    // If inj_at >= 0, a done carrying inj_res is pulsed that many cycles
    // into the frame.
    task automatic recv_frame(input string name, input logic [55:0] exp,
                              input int inj_at, input logic [7:0] inj_res);
        logic [7:0] eb;
        logic [7:0] got;
        logic       ebit;
        logic       timing_ok;
        int         idx;
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            eb        = exp[55 - 8*k -: 8];
            got       = 8'h00;
            timing_ok = 1'b1;
            for (int b = 0; b < NBITS; b++) begin
                if (b == 0)                      ebit = 1'b0;
                else if (b <= 8)                 ebit = eb[b-1];
                else if (NBITS == 11 && b == 9)  ebit = ^eb;
                else                             ebit = 1'b1;
                for (int j = 0; j < CPB; j++) begin
                    if (uart_tx !== ebit || busy !== 1'b1) timing_ok = 1'b0;
                    if (j == CPB/2 && b >= 1 && b <= 8) got[b-1] = uart_tx;
                    if (idx == inj_at) begin
                        done   = 1'b1;
                        result = inj_res;
                    end else begin
                        done = 1'b0;
                    end
                    idx++;
                    @(negedge clk);
                end
            end
            check($sformatf("%s byte%0d", name, k), {24'd0, got}, {24'd0, eb});
            check($sformatf("%s bits_byte%0d", name, k), {31'd0, timing_ok}, 32'd1);
        end
        check($sformatf("%s busy_after", name), {31'd0, busy}, 32'd0);
        check($sformatf("%s tx_after", name), {31'd0, uart_tx}, 32'd1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic idle_ok;

        vecs[0] = '{gap: 1000, res: 8'h07, frame: 56'hA5_07_00_00_03_E8_EC};
        vecs[1] = '{gap: -1,   res: 8'h42, frame: 56'hA5_42_00_00_00_00_42};
        vecs[2] = '{gap: 1,    res: 8'hFF, frame: 56'hA5_FF_00_00_00_01_FE};
        vecs[3] = '{gap: 300,  res: 8'h5A, frame: 56'hA5_5A_00_00_01_2C_77};
        vecs[4] = '{gap: 2748, res: 8'h81, frame: 56'hA5_81_00_00_0A_BC_37};

        rst    = 1'b1;
        start  = 1'b0;
        done   = 1'b0;
        result = 8'h00;
        repeat (3) @(negedge clk);
        check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        check("reset led_result", {24'd0, led_result}, 32'd0);
        rst = 1'b0;

        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        check("idle line quiet", {31'd0, idle_ok}, 32'd1);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].gap >= 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (vecs[v].gap - 1) @(negedge clk);
            end
            send_done(vecs[v].res);
            check($sformatf("vec%0d led_result", v), {24'd0, led_result}, {24'd0, vecs[v].res});
            check($sformatf("vec%0d busy_rise", v), {31'd0, busy}, 32'd1);
            recv_frame($sformatf("vec%0d", v), vecs[v].frame, -1, 8'h00);
        end

        // Overrun: a second done 200 cycles into a frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        send_done(8'h11);
        recv_frame("ovr", 56'hA5_11_00_00_00_32_23, 200, 8'h03);
        check("ovr overrun set", {31'd0, overrun}, 32'd1);
        check("ovr led_result", {24'd0, led_result}, 32'h03);
        send_done(8'h3C);
        check("ovr third busy", {31'd0, busy}, 32'd1);
        recv_frame("ovr3", 56'hA5_3C_00_00_00_00_3C, -1, 8'h00);
        check("ovr overrun sticky", {31'd0, overrun}, 32'd1);

        // start and done in the same cycle, five cycles after a start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        done   = 1'b1;
        result = 8'h99;
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
        check("same led_result", {24'd0, led_result}, 32'h99);
        recv_frame("same", 56'hA5_99_00_00_00_05_9C, -1, 8'h00);
        // The restarted run kept counting through the whole frame.
        send_done(8'h01);
`ifdef CNN_UART_PARITY_EN
        recv_frame("rerun", 56'hA5_01_00_00_03_03_01, -1, 8'h00);
`else
        recv_frame("rerun", 56'hA5_01_00_00_02_BD_BE, -1, 8'h00);
`endif

        // Reset in the middle of byte 3's start bit.
        send_done(8'h55);
        repeat (3 * NBITS * CPB + 2) @(negedge clk);
        check("midrst pre tx", {31'd0, uart_tx}, 32'd0);
        check("midrst pre busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst overrun", {31'd0, overrun}, 32'd0);
        check("midrst led_result", {24'd0, led_result}, 32'd0);
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (FRAME_CYC / 7) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        check("midrst stays idle", {31'd0, idle_ok}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
